// File: rtl/tone_sequencer.sv
// tone_sequencer: steps through a note table of {phase step, duration} entries,
// driving an oscillator step/enable for each note's duration in ticks.
module tone_sequencer #(
   parameter int NOTES    = 16,
   parameter int TICK_DIV = 48000,
   parameter int DUR_W    = 16,
   localparam int IW      = $clog2(NOTES),
   localparam int TW      = $clog2(TICK_DIV)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             stop,
   input  logic             loop,
   input  logic             wr_en,
   input  logic [IW-1:0]    wr_addr,
   input  logic [7:0]       wr_step,
   input  logic [DUR_W-1:0] wr_dur,
   output logic [7:0]       step,
   output logic             voice_en,
   output logic             busy,
   output logic             done,
   output logic [IW-1:0]    cur_idx
);
   typedef enum logic [2:0] {IDLE, FETCH, EVAL, PLAY, DONE} state_t;
   state_t             state_q;
   logic [DUR_W+7:0]   mem [NOTES];
   logic [DUR_W+7:0]   rd_q;
   logic [7:0]         step_q;
   logic               voice_q, done_q;
   logic [IW-1:0]      idx_q;
   logic [TW-1:0]      tick_q;
   logic [DUR_W-1:0]   dur_q;
   logic [7:0]         rd_step;
   logic [DUR_W-1:0]   rd_dur;
   logic               tick, last_idx;
   assign rd_step  = rd_q[DUR_W+7:DUR_W];
   assign rd_dur   = rd_q[DUR_W-1:0];
   assign tick     = tick_q == TW'(TICK_DIV - 1);
   assign last_idx = idx_q == IW'(NOTES - 1);
   assign step     = step_q;
   assign voice_en = voice_q;
   assign done     = done_q;
   assign busy     = state_q != IDLE;
   assign cur_idx  = idx_q;
   // idx only changes on the FETCH entry edge, so rd_q holds the fetched entry in EVAL
   always_ff @(posedge clk) begin
      if (wr_en) mem[wr_addr] <= {wr_step, wr_dur};
      rd_q <= mem[idx_q];
   end
   always_ff @(posedge clk) begin
      if (!rst || stop) begin
         state_q <= IDLE;
         step_q  <= '0;
         voice_q <= 1'b0;
         done_q  <= 1'b0;
         idx_q   <= '0;
         tick_q  <= '0;
         dur_q   <= '0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            IDLE: if (start) begin
               state_q <= FETCH;
               idx_q   <= '0;
            end
            FETCH: state_q <= EVAL;
            EVAL: if (rd_dur != '0) begin
               dur_q   <= rd_dur;
               tick_q  <= '0;
               step_q  <= rd_step;
               voice_q <= rd_step != '0;
               state_q <= PLAY;
            end else if (loop && idx_q != '0) begin
               idx_q   <= '0;
               state_q <= FETCH;
            end else begin
               state_q <= DONE;
               done_q  <= 1'b1;
               step_q  <= '0;
               voice_q <= 1'b0;
               idx_q   <= '0;
            end
            PLAY: begin
               tick_q <= tick ? '0 : tick_q + 1'b1;
               if (tick) begin
                  dur_q <= dur_q - 1'b1;
                  if (dur_q == DUR_W'(1)) begin
                     if (!last_idx) begin
                        idx_q   <= idx_q + 1'b1;
                        state_q <= FETCH;
                     end else if (loop) begin
                        idx_q   <= '0;
                        state_q <= FETCH;
                     end else begin
                        state_q <= DONE;
                        done_q  <= 1'b1;
                        step_q  <= '0;
                        voice_q <= 1'b0;
                        idx_q   <= '0;
                     end
                  end
               end
            end
            DONE: state_q <= IDLE;
            default: state_q <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_tone_sequencer.sv
// tb_tone_sequencer: directed traces with hand-computed per-cycle expectations
// of {step, voice_en, done, busy, cur_idx}.
module tb_tone_sequencer;
   logic       clk = 1'b0;
   logic       rst, start, stop, loop, wr_en;
   logic [1:0] wr_addr;
   logic [7:0] wr_step;
   logic [7:0] wr_dur;
   logic [7:0] step;
   logic       voice_en, busy, done;
   logic [1:0] cur_idx;
   logic [12:0] obs;
   logic [12:0] exp_q [$];
   int vectors = 0;
   int miscompares = 0;

   tone_sequencer #(.NOTES(4), .TICK_DIV(4), .DUR_W(8)) dut (
      .clk(clk), .rst(rst), .start(start), .stop(stop), .loop(loop),
      .wr_en(wr_en), .wr_addr(wr_addr), .wr_step(wr_step), .wr_dur(wr_dur),
      .step(step), .voice_en(voice_en), .busy(busy), .done(done), .cur_idx(cur_idx)
   );

   always #5 clk = ~clk;
   assign obs = {step, voice_en, done, busy, cur_idx};

   task automatic tick1();
      @(posedge clk);
      #1;
   endtask

   task automatic push(input int n, input logic [7:0] s, input logic v, input logic d,
                       input logic b, input logic [1:0] i);
      repeat (n) exp_q.push_back({s, v, d, b, i});
   endtask

   task automatic write_entry(input logic [1:0] a, input logic [7:0] s, input logic [7:0] d);
      wr_en = 1'b1; wr_addr = a; wr_step = s; wr_dur = d;
      tick1();
      wr_en = 1'b0;
   endtask

   task automatic pulse_start();
      start = 1'b1;
      tick1();
      start = 1'b0;
   endtask

   task automatic load_a();
      write_entry(0, 10, 2);
      write_entry(1, 0, 1);
      write_entry(2, 20, 1);
      write_entry(3, 99, 0);
   endtask

   task automatic load_b();
      write_entry(0, 5, 1);
      write_entry(1, 6, 1);
      write_entry(2, 7, 1);
      write_entry(3, 8, 1);
   endtask

   task automatic test_reset();
      rst = 1'b0; start = 1'b1;
      for (int k = 0; k < 3; k++) begin
         tick1();
         vectors++;
         if (obs !== 13'h0) begin
            miscompares++;
            $display("FAIL reset[%0d]: got %h want %h", k, obs, 13'h0);
         end
      end
      start = 1'b0; rst = 1'b1;
      tick1();
      vectors++;
      if (obs !== 13'h0) begin
         miscompares++;
         $display("FAIL reset_release: got %h want %h", obs, 13'h0);
      end
   endtask

   task automatic test_basic();
      loop = 1'b0;
      load_a();
      push(2, 0, 0, 0, 1, 0); push(8, 10, 1, 0, 1, 0); push(2, 10, 1, 0, 1, 1);
      push(4, 0, 0, 0, 1, 1); push(2, 0, 0, 0, 1, 2); push(4, 20, 1, 0, 1, 2);
      push(2, 20, 1, 0, 1, 3); push(1, 0, 0, 1, 1, 0); push(3, 0, 0, 0, 0, 0);
      pulse_start();
      foreach (exp_q[k]) begin
         vectors++;
         if (obs !== exp_q[k]) begin
            miscompares++;
            $display("FAIL basic[%0d]: got %h want %h", k, obs, exp_q[k]);
         end
         start = (k == 5);
         tick1();
      end
      start = 1'b0;
      exp_q.delete();
   endtask

   task automatic test_loop_write();
      loop = 1'b1;
      load_a();
      push(2, 0, 0, 0, 1, 0); push(8, 10, 1, 0, 1, 0); push(2, 10, 1, 0, 1, 1);
      push(4, 0, 0, 0, 1, 1); push(2, 0, 0, 0, 1, 2); push(4, 20, 1, 0, 1, 2);
      push(2, 20, 1, 0, 1, 3); push(2, 20, 1, 0, 1, 0); push(4, 30, 1, 0, 1, 0);
      push(2, 0, 0, 0, 0, 0);
      wr_addr = 0; wr_step = 30; wr_dur = 2;
      pulse_start();
      foreach (exp_q[k]) begin
         vectors++;
         if (obs !== exp_q[k]) begin
            miscompares++;
            $display("FAIL loop_write[%0d]: got %h want %h", k, obs, exp_q[k]);
         end
         wr_en = (k == 3);
         stop = (k == 29);
         tick1();
      end
      wr_en = 1'b0; stop = 1'b0;
      exp_q.delete();
   endtask

   task automatic test_full(input logic lp);
      loop = lp;
      load_b();
      push(2, 0, 0, 0, 1, 0); push(4, 5, 1, 0, 1, 0); push(2, 5, 1, 0, 1, 1);
      push(4, 6, 1, 0, 1, 1); push(2, 6, 1, 0, 1, 2); push(4, 7, 1, 0, 1, 2);
      push(2, 7, 1, 0, 1, 3); push(4, 8, 1, 0, 1, 3);
      if (lp) begin
         push(2, 8, 1, 0, 1, 0); push(4, 5, 1, 0, 1, 0); push(1, 0, 0, 0, 0, 0);
      end else begin
         push(1, 0, 0, 1, 1, 0); push(2, 0, 0, 0, 0, 0);
      end
      pulse_start();
      foreach (exp_q[k]) begin
         vectors++;
         if (obs !== exp_q[k]) begin
            miscompares++;
            $display("FAIL full_loop%0d[%0d]: got %h want %h", lp, k, obs, exp_q[k]);
         end
         stop = lp && (k == 29);
         tick1();
      end
      stop = 1'b0;
      exp_q.delete();
   endtask

   task automatic test_marker();
      loop = 1'b1;
      write_entry(0, 7, 0);
      push(2, 0, 0, 0, 1, 0); push(1, 0, 0, 1, 1, 0); push(2, 0, 0, 0, 0, 0);
      pulse_start();
      foreach (exp_q[k]) begin
         vectors++;
         if (obs !== exp_q[k]) begin
            miscompares++;
            $display("FAIL marker[%0d]: got %h want %h", k, obs, exp_q[k]);
         end
         tick1();
      end
      exp_q.delete();
   endtask

   task automatic test_start_stop();
      load_b();
      start = 1'b1; stop = 1'b1;
      tick1();
      start = 1'b0; stop = 1'b0;
      for (int k = 0; k < 2; k++) begin
         vectors++;
         if (obs !== 13'h0) begin
            miscompares++;
            $display("FAIL start_stop[%0d]: got %h want %h", k, obs, 13'h0);
         end
         tick1();
      end
   endtask

   task automatic test_reset_mid_play();
      loop = 1'b0;
      load_b();
      push(2, 0, 0, 0, 1, 0); push(2, 5, 1, 0, 1, 0); push(2, 0, 0, 0, 0, 0);
      pulse_start();
      foreach (exp_q[k]) begin
         vectors++;
         if (obs !== exp_q[k]) begin
            miscompares++;
            $display("FAIL reset_play[%0d]: got %h want %h", k, obs, exp_q[k]);
         end
         rst = !(k == 3);
         start = (k == 3);
         tick1();
      end
      rst = 1'b1; start = 1'b0;
      exp_q.delete();
      push(2, 0, 0, 0, 1, 0); push(4, 5, 1, 0, 1, 0); push(2, 5, 1, 0, 1, 1);
      push(4, 6, 1, 0, 1, 1); push(2, 6, 1, 0, 1, 2);
      pulse_start();
      foreach (exp_q[k]) begin
         vectors++;
         if (obs !== exp_q[k]) begin
            miscompares++;
            $display("FAIL replay[%0d]: got %h want %h", k, obs, exp_q[k]);
         end
         stop = (k == 13);
         tick1();
      end
      stop = 1'b0;
      exp_q.delete();
   endtask

   initial begin
      rst = 1'b0; start = 1'b0; stop = 1'b0; loop = 1'b0;
      wr_en = 1'b0; wr_addr = '0; wr_step = '0; wr_dur = '0;
      #1;
      test_reset();
      test_basic();
      test_loop_write();
      test_full(1'b0);
      test_full(1'b1);
      test_marker();
      test_start_stop();
      test_reset_mid_play();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule

// File: doc/tone_sequencer.md
TONE_SEQUENCER -- requirements
Module: tone_sequencer

Interface
REQ-001 Parameter NOTES, default 16, sets the note-table depth (power of 2, at least 2); the index width is IW = log2(NOTES).
REQ-002 Parameter TICK_DIV, default 48000, sets the number of clk cycles per duration tick (at least 2).
REQ-003 Parameter DUR_W, default 16, sets the width of the duration field in ticks.
REQ-004 Port clk: input, 1 bit, single clock; all logic is on the rising edge.
REQ-005 Port rst: input, 1 bit, synchronous active-low reset (0 = reset).
REQ-006 Port start: input, 1 bit, request to begin playback from index 0.
REQ-007 Port stop: input, 1 bit, request to abort playback.
REQ-008 Port loop: input, 1 bit, level; when high, the end of the sequence restarts at index 0.
REQ-009 Port wr_en: input, 1 bit, note-table write strobe.
REQ-010 Port wr_addr: input, IW bits, note-table write address.
REQ-011 Port wr_step: input, 8 bits, phase step to store (0 = rest).
REQ-012 Port wr_dur: input, DUR_W bits, duration in ticks to store (0 = end marker).
REQ-013 Port step: output, 8 bits, phase increment for the wavetable oscillator.
REQ-014 Port voice_en: output, 1 bit, oscillator/PDM enable.
REQ-015 Port busy: output, 1 bit, high in every state except IDLE.
REQ-016 Port done: output, 1 bit, one-cycle pulse on normal sequence end.
REQ-017 Port cur_idx: output, IW bits, table index currently fetched or playing.

Function
REQ-018 Note table shall be NOTES entries of {step[7:0], dur[DUR_W-1:0]} with a synchronous write and a registered, 1-cycle-latency read.
REQ-019 Same-cycle write and read to the same address shall return the old data; writes are legal in any state.
REQ-020 State machine states shall be IDLE, FETCH, EVAL, PLAY and DONE.
REQ-021 IDLE transitions:
- start=1 and stop=0: go to FETCH.
- Set idx to 0.
- Other inputs: remain in IDLE.
REQ-022 FETCH shall issue the table read at idx and go to EVAL on the next cycle.
REQ-023 EVAL, for an entry with dur!=0:
- Load dur_cnt=dur.
- Clear tick_cnt.
- Drive step=entry step.
- Drive voice_en = (entry step != 0).
- Go to PLAY.
REQ-024 EVAL, for an entry with dur=0 (end marker):
- loop=1 and idx!=0: set idx=0 and go to FETCH.
- Otherwise: go to DONE.
- A marker at index 0 never loops.
REQ-025 PLAY, tick_cnt behaviour: counts 0..TICK_DIV-1 and wraps; a tick occurs when tick_cnt=TICK_DIV-1.
REQ-026 PLAY, each tick: dur_cnt decrements.
REQ-027 PLAY, tick with dur_cnt=1:
- idx=NOTES-1: treat as an end marker per REQ-024 (wrap to 0 if loop=1, else DONE).
- Otherwise: idx increments and the FETCH to the next entry happens on the next cycle.
REQ-028 A note of duration d shall hold step/voice_en for exactly d*TICK_DIV PLAY cycles.
REQ-029 During FETCH and EVAL between notes, step and voice_en shall keep their previous values, giving a 2-cycle gap and no glitch.
REQ-030 DONE shall:
- Assert done for exactly one cycle.
- Drive step=0 and voice_en=0.
- Go to IDLE.
REQ-031 stop=1 in any state shall force IDLE on the next edge with step=0, voice_en=0, no done pulse, and idx=0.
REQ-032 stop shall have priority over start and over all internal transitions.
REQ-033 start while busy=1 shall be ignored.
REQ-034 loop shall be sampled only at end-marker or idx-wrap decisions.
REQ-035 Counter widths shall be: tick_cnt ceil(log2(TICK_DIV)) bits; dur_cnt DUR_W bits; idx IW bits with modulo wrap.

Reset
REQ-036 While rst=0 at a clock edge:
- State becomes IDLE.
- step=0, voice_en=0, busy=0, done=0, cur_idx=0.
- tick_cnt=0, dur_cnt=0.
REQ-037 Reset shall not clear note-table contents (table contents are unspecified after power-up).
REQ-038 Reset asserted mid-PLAY shall take effect on that edge, regardless of start and stop.

Verification (TICK_DIV=4, NOTES=4, DUR_W=8)
REQ-039 Table {(10,2),(0,1),(20,1),(x,0)}, loop=0, start pulse:
- step=10 with voice_en=1 for 8 cycles.
- voice_en=0 for 4 cycles (rest).
- step=20 for 4 cycles.
- done pulses once, then busy=0.
REQ-040 Same table with loop=1: after the index-2 note, the next note is index 0 with step=10; done never pulses; stop then returns to IDLE in 1 cycle with voice_en=0 and no done.
REQ-041 Table full with dur!=0 at all 4 entries, loop=0: after index 3 the sequence goes to DONE; with loop=1 it wraps to index 0.
REQ-042 Entry 0 is an end marker with loop=1: done pulses within 3 cycles of start; no hang.
REQ-043 Simultaneous events:
- start and stop in the same cycle: stays IDLE.
- start during PLAY: no effect.
- Write to the currently playing address: the current note is unchanged and the next pass uses the new data.
REQ-044 rst=0 during PLAY: on the next edge, all outputs are at reset values; after release, a start replays the table intact.
